// File: rtl/scoreboard_register_file.sv
// Register file with per-register pending (scoreboard) bits, two write ports,
// two combinational read ports with optional forwarding, and a sweep-clear FSM.
module scoreboard_register_file #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_W-1:0]             rd_addr_a,
   input  logic [ADDR_W-1:0]             rd_addr_b,
   output logic [DATA_W-1:0]             rd_data_a,
   output logic [DATA_W-1:0]             rd_data_b,
   output logic                          rd_pend_a,
   output logic                          rd_pend_b,
   input  logic                          we0,
   input  logic                          we1,
   input  logic [ADDR_W-1:0]             waddr0,
   input  logic [ADDR_W-1:0]             waddr1,
   input  logic [DATA_W-1:0]             wdata0,
   input  logic [DATA_W-1:0]             wdata1,
   input  logic                          rsv_en,
   input  logic [ADDR_W-1:0]             rsv_addr,
   input  logic                          clr_req,
   output logic                          busy,
   output logic [(2**ADDR_W)*DATA_W-1:0] dbg_regs
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic [DATA_W-1:0]   regs_d [DEPTH];
   logic [DEPTH-1:0]    pend_q, pend_d;

   logic                wr_ok0, wr_ok1, rsv_ok;
   logic [ADDR_W-1:0]   rd_addr [2];
   logic [DATA_W-1:0]   rd_data [2];
   logic                rd_pend [2];

   // Accesses to a hard-wired zero register are discarded up front so that
   // neither the update path nor the forwarding path has to special-case them.
   always_comb begin
      wr_ok0 = we0    && (state_q == IDLE) && !((ZERO_REG != 0) && (waddr0 == '0));
      wr_ok1 = we1    && (state_q == IDLE) && !((ZERO_REG != 0) && (waddr1 == '0));
      rsv_ok = rsv_en && (state_q == IDLE) && !((ZERO_REG != 0) && (rsv_addr == '0));
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      regs_d  = regs_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
            // Port 1 is applied last so it wins a same-address collision;
            // the reserve comes after both writes so it leaves the bit set.
            if (wr_ok0) begin
               regs_d[waddr0] = wdata0;
               pend_d[waddr0] = 1'b0;
            end
            if (wr_ok1) begin
               regs_d[waddr1] = wdata1;
               pend_d[waddr1] = 1'b0;
            end
            if (rsv_ok) begin
               pend_d[rsv_addr] = 1'b1;
            end
         end
         CLEAR: begin
            regs_d[idx_q] = '0;
            pend_d[idx_q] = 1'b0;
            idx_d         = idx_q + 1'b1;
            if (idx_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pend_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign rd_addr[0] = rd_addr_a;
   assign rd_addr[1] = rd_addr_b;

   // Forwarding only applies in IDLE; wr_ok*/rsv_ok are already gated by it.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs_q[rd_addr[p]];
         rd_pend[p] = pend_q[rd_addr[p]];
         if (BYPASS != 0) begin
            if (wr_ok0 && (waddr0 == rd_addr[p])) begin
               rd_data[p] = wdata0;
               rd_pend[p] = 1'b0;
            end
            if (wr_ok1 && (waddr1 == rd_addr[p])) begin
               rd_data[p] = wdata1;
               rd_pend[p] = 1'b0;
            end
            if (((wr_ok0 && (waddr0 == rd_addr[p])) || (wr_ok1 && (waddr1 == rd_addr[p])))
                && rsv_ok && (rsv_addr == rd_addr[p])) begin
               rd_pend[p] = 1'b1;
            end
         end
         if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
            rd_data[p] = '0;
            rd_pend[p] = 1'b0;
         end
      end
   end

   assign rd_data_a = rd_data[0];
   assign rd_data_b = rd_data[1];
   assign rd_pend_a = rd_pend[0];
   assign rd_pend_b = rd_pend[1];
   assign busy      = (state_q == CLEAR);

   always_comb begin
      dbg_regs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         dbg_regs[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Scoreboard bench: the driver queues hand-computed expectations tagged with
// their cycle, and a negedge monitor pops and compares them against the DUT.
module tb_scoreboard_register_file;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   localparam int K_DATA_A = 0;
   localparam int K_PEND_A = 1;
   localparam int K_DATA_B = 2;
   localparam int K_PEND_B = 3;
   localparam int K_BUSY   = 4;
   localparam int K_DBG    = 5;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [ADDR_W-1:0]       rd_addr_a, rd_addr_b;
   logic [DATA_W-1:0]       rd_data_a, rd_data_b;
   logic                    rd_pend_a, rd_pend_b;
   logic                    we0, we1;
   logic [ADDR_W-1:0]       waddr0, waddr1;
   logic [DATA_W-1:0]       wdata0, wdata1;
   logic                    rsv_en;
   logic [ADDR_W-1:0]       rsv_addr;
   logic                    clr_req;
   logic                    busy;
   logic [DEPTH*DATA_W-1:0] dbg_regs;

   typedef struct {
      int          cyc;
      string       name;
      int          kind;
      logic [63:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   cyc        = 0;
   int   n_compared = 0;
   int   n_failed   = 0;

   scoreboard_register_file #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .rd_pend_a(rd_pend_a), .rd_pend_b(rd_pend_b),
      .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .clr_req(clr_req), .busy(busy), .dbg_regs(dbg_regs)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: everything tagged for the current cycle is checked mid-cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t        e;
         logic [63:0] act;
         e = exp_q.pop_front();
         case (e.kind)
            K_DATA_A: act = 64'(rd_data_a);
            K_PEND_A: act = 64'(rd_pend_a);
            K_DATA_B: act = 64'(rd_data_b);
            K_PEND_B: act = 64'(rd_pend_b);
            K_BUSY:   act = 64'(busy);
            default:  act = 64'(dbg_regs);
         endcase
         n_compared++;
         if (e.cyc < cyc) begin
            n_failed++;
            $display("[TB] FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
         end else if (act !== e.exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, act, e.exp, cyc);
         end
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic i_we0, input int i_wa0, input int i_wd0,
                                input logic i_we1, input int i_wa1, input int i_wd1,
                                input logic i_rsv, input int i_ra, input logic i_clr,
                                input int i_rda, input int i_rdb);
      we0       = i_we0;
      waddr0    = ADDR_W'(i_wa0);
      wdata0    = DATA_W'(i_wd0);
      we1       = i_we1;
      waddr1    = ADDR_W'(i_wa1);
      wdata1    = DATA_W'(i_wd1);
      rsv_en    = i_rsv;
      rsv_addr  = ADDR_W'(i_ra);
      clr_req   = i_clr;
      rd_addr_a = ADDR_W'(i_rda);
      rd_addr_b = ADDR_W'(i_rdb);
   endtask

   task automatic idle(input int rda, input int rdb);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, rda, rdb);
   endtask

   task automatic checkOutput(input string name, input int kind, input logic [63:0] exp);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      idle(0, 0);
      nextCycle();
      nextCycle();
      checkOutput("reset_busy", K_BUSY, 64'h0);
      checkOutput("reset_regs", K_DBG, 64'h0);
      checkOutput("reset_pend5", K_PEND_A, 64'h0);
      rst = 1'b0;

      // Dual write to addr 3: port 1 data must win, both forwarded and stored.
      nextCycle();
      applyStimulus(1, 3, 8'h11, 1, 3, 8'h22, 0, 0, 0, 3, 3);
      checkOutput("dual_bypass", K_DATA_A, 64'h22);
      nextCycle();
      idle(3, 0);
      checkOutput("dual_stored", K_DATA_A, 64'h22);
      checkOutput("dual_pend", K_PEND_A, 64'h0);

      // Reserve, then write, then reserve+write on addr 5.
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0);
      checkOutput("rsv_same_cycle_pend", K_PEND_A, 64'h0);
      nextCycle();
      idle(5, 0);
      checkOutput("rsv_pend_set", K_PEND_A, 64'h1);
      nextCycle();
      applyStimulus(1, 5, 8'h7E, 0, 0, 0, 0, 0, 0, 5, 0);
      checkOutput("wr5_bypass_data", K_DATA_A, 64'h7E);
      checkOutput("wr5_bypass_pend", K_PEND_A, 64'h0);
      nextCycle();
      idle(5, 0);
      checkOutput("wr5_data", K_DATA_A, 64'h7E);
      checkOutput("wr5_pend_clear", K_PEND_A, 64'h0);
      nextCycle();
      applyStimulus(0, 0, 0, 1, 5, 8'h33, 1, 5, 0, 0, 5);
      checkOutput("rsvwr_bypass_data", K_DATA_B, 64'h33);
      checkOutput("rsvwr_bypass_pend", K_PEND_B, 64'h1);
      nextCycle();
      idle(0, 5);
      checkOutput("rsvwr_data", K_DATA_B, 64'h33);
      checkOutput("rsvwr_pend", K_PEND_B, 64'h1);

      // Forwarding on addr 2.
      nextCycle();
      applyStimulus(1, 2, 8'h5A, 0, 0, 0, 0, 0, 0, 2, 2);
      checkOutput("bypass2_a", K_DATA_A, 64'h5A);
      checkOutput("bypass2_b", K_DATA_B, 64'h5A);

      // Zero register ignores writes and reserves.
      nextCycle();
      applyStimulus(1, 0, 8'hFF, 0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("zero_bypass_data", K_DATA_A, 64'h0);
      checkOutput("zero_bypass_pend", K_PEND_A, 64'h0);
      nextCycle();
      idle(0, 0);
      checkOutput("zero_data", K_DATA_A, 64'h0);
      checkOutput("zero_pend", K_PEND_A, 64'h0);
      checkOutput("regs_snapshot", K_DBG, 64'h0000_3300_225A_0000);

      // Fill registers 1..7 with 0x11..0x17, then reserve 4.
      for (int i = 1; i < DEPTH; i++) begin
         nextCycle();
         applyStimulus(1, i, 8'h10 + i, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
      checkOutput("fill_regs", K_DBG, 64'h1716_1514_1312_1100);

      // Accepted clr_req: the same-cycle write to 6 is still performed.
      nextCycle();
      applyStimulus(1, 6, 8'h66, 0, 0, 0, 0, 0, 1, 6, 4);
      checkOutput("clr_cycle_busy", K_BUSY, 64'h0);
      checkOutput("clr_cycle_bypass", K_DATA_A, 64'h66);
      checkOutput("clr_cycle_pend4", K_PEND_B, 64'h1);
      for (int s = 1; s <= DEPTH; s++) begin
         nextCycle();
         idle(0, 0);
         if (s == 1) begin
            applyStimulus(0, 0, 0, 1, 7, 8'hAA, 1, 7, 0, 7, 6);
            checkOutput("sweep_no_bypass", K_DATA_A, 64'h17);
            checkOutput("sweep_no_rsv_pend", K_PEND_A, 64'h0);
            checkOutput("sweep_clr_write_kept", K_DATA_B, 64'h66);
         end
         if (s == 2) begin
            idle(4, 0);
            checkOutput("sweep_pend4_still", K_PEND_A, 64'h1);
         end
         if (s == 4) applyStimulus(1, 1, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 0);
         if (s == 5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
         checkOutput($sformatf("sweep_busy_%0d", s), K_BUSY, 64'h1);
      end
      nextCycle();
      idle(4, 1);
      checkOutput("sweep_done_busy", K_BUSY, 64'h0);
      checkOutput("sweep_done_regs", K_DBG, 64'h0);
      checkOutput("sweep_done_pend4", K_PEND_A, 64'h0);
      checkOutput("sweep_lost_write", K_DATA_B, 64'h0);
      nextCycle();
      idle(0, 0);
      checkOutput("sweep_no_restart", K_BUSY, 64'h0);

      // Reset during sweep cycle 3.
      nextCycle();
      applyStimulus(1, 3, 8'h99, 0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      nextCycle();
      idle(0, 0);
      checkOutput("rsweep_busy1", K_BUSY, 64'h1);
      nextCycle();
      idle(0, 0);
      checkOutput("rsweep_reg3_kept", K_DBG, 64'h0000_0000_9900_0000);
      nextCycle();
      idle(0, 0);
      rst = 1'b1;
      checkOutput("rsweep_busy3", K_BUSY, 64'h1);
      nextCycle();
      rst = 1'b0;
      checkOutput("rsweep_after_busy", K_BUSY, 64'h0);
      checkOutput("rsweep_after_regs", K_DBG, 64'h0);

      // Drain the scoreboard with a bounded wait.
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) nextCycle();
      if (exp_q.size() > 0) begin
         n_failed += exp_q.size();
         n_compared += exp_q.size();
         $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, SHALL hard-wire register 0 to zero when 1.
REQ-004 Parameter BYPASS, default 1, SHALL enable same-cycle write-to-read forwarding when 1.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The ports SHALL be as follows (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses
- rd_data_a, rd_data_b  out  DATA_W  combinational read data
- rd_pend_a, rd_pend_b  out  1  combinational pending flag of the addressed register
- we0, we1  in  1  write enables
- waddr0, waddr1  in  ADDR_W  write addresses
- wdata0, wdata1  in  DATA_W  write data
- rsv_en  in  1  reserve request; marks rsv_addr pending
- rsv_addr  in  ADDR_W  reserve address
- clr_req  in  1  start a sweep clear
- busy  out  1  sweep clear in progress
- dbg_regs  out  DEPTH*DATA_W  flattened contents; register i at bits [i*DATA_W +: DATA_W]

Function
REQ-007 Writes SHALL take effect on the rising clk edge; reads SHALL be combinational.
REQ-008 When we0 and we1 target the same address in one cycle, port 1 data SHALL be stored.
REQ-009 A write SHALL clear the pending bit of the written address at the same edge.
REQ-010 rsv_en SHALL set the pending bit of rsv_addr at the edge.
REQ-011 When a reserve and a write target the same address in one cycle, the data SHALL be stored and the pending bit SHALL end set.
REQ-012 With ZERO_REG=1, address 0 SHALL read 0 with pend 0, and writes and reserves to address 0 SHALL be ignored.
REQ-013 With BYPASS=1, a read of an address written this cycle SHALL return the write data, with port 1 priority.
REQ-014 With BYPASS=1, pend for that read SHALL be 0 unless the same address is also reserved this cycle.
REQ-015 With BYPASS=0, reads SHALL return stored contents only.
REQ-016 FSM states SHALL be IDLE and CLEAR.
REQ-017 In IDLE, clr_req SHALL move the FSM to CLEAR with index counter = 0.
REQ-018 In CLEAR, the FSM SHALL zero register[index] and its pending bit each cycle, then increment index.
REQ-019 After index DEPTH-1 is cleared, the FSM SHALL return to IDLE; the sweep SHALL take exactly DEPTH cycles.
REQ-020 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-021 In CLEAR, writes and reserves SHALL be dropped, with no effect.
REQ-022 In CLEAR, reads SHALL return current stored contents with no bypass.
REQ-023 In CLEAR, clr_req SHALL be ignored.
REQ-024 A write or reserve in the same cycle as an accepted clr_req in IDLE SHALL be performed normally.

Reset
REQ-025 rst SHALL zero all registers and all pending bits, force IDLE, zero the index, drive busy 0, and override every other input including mid-sweep.

Verification
REQ-026 Dual write: we0 and we1 both write addr 3 (0x11, 0x22) -> reg3=0x22 next cycle, pend3=0.
REQ-027 Scoreboard: rsv addr 5 -> rd_pend=1; later write 0x7E to addr 5 -> pend=0, data 0x7E; reserve and write addr 5 in the same cycle -> data stored, pend=1.
REQ-028 Bypass: write 0x5A to addr 2 while reading addr 2 -> rd_data=0x5A that cycle (BYPASS=1), or the old value (BYPASS=0).
REQ-029 Zero reg: write 0xFF and reserve addr 0 -> reads 0x00 with pend 0.
REQ-030 Sweep: fill all registers, pulse clr_req -> busy high exactly 8 cycles (default), all registers 0 afterward, a write issued mid-sweep is lost.
REQ-031 Reset mid-sweep: assert rst in sweep cycle 3 -> busy 0 and all registers 0 the next cycle.
